// File: rtl/pic_ctl.sv
// pic_ctl: 8259-style interrupt controller with eight edge-triggered lines and fixed priority (IR0 highest).
// Latency: an ir edge sets IRR one cycle later; irq_signal rises the cycle after that. dout is valid the cycle after rd.
// Backpressure: the request holds irq/irq_signal until irq_ack, then stays idle for at least one cycle.
module pic_ctl #(
  parameter logic [7:0] VECTOR_RESET   = 8'h08,
  parameter bit         AUTO_EOI_RESET = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] ir,
  input  logic       a0,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq_signal,
  output logic [7:0] irq,
  input  logic       irq_ack
);

  typedef enum logic [1:0] {INIT_READY, INIT_ICW2, INIT_ICW3, INIT_ICW4} init_e;
  typedef enum logic {REQ_IDLE, REQ_ACTIVE} req_e;

  init_e      init_q, init_d;
  req_e       req_q, req_d;
  logic [7:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
  logic [7:0] base_q, base_d, ir_prev_q, dout_q, dout_d, irq_q, irq_d;
  logic       aeoi_q, aeoi_d, read_sel_q, read_sel_d;
  logic       single_q, single_d, icw4_q, icw4_d, irq_sig_q, irq_sig_d;
  logic [2:0] cur_q, cur_d;

  logic [7:0] pend, ir_edge, irr_clr, isr_set, isr_clr;
  logic       cand_vld, isr_any, icw1;
  logic [2:0] cand_idx, isr_low;

  // Pick the highest-priority unmasked request and block it unless it outranks every in-service line.
  always_comb begin
    pend     = irr_q & ~imr_q;
    cand_vld = 1'b0;
    cand_idx = 3'd0;
    isr_any  = 1'b0;
    isr_low  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) begin
        cand_vld = 1'b1;
        cand_idx = 3'(i);
      end
      if (isr_q[i]) begin
        isr_any = 1'b1;
        isr_low = 3'(i);
      end
    end
    if (isr_any && (cand_idx >= isr_low)) cand_vld = 1'b0;
  end

  assign ir_edge = ir & ~ir_prev_q;
  assign icw1    = wr && !a0 && din[4];

  // Next-state for the request sequencer, init sequencer, register writes and reads.
  always_comb begin
    init_d     = init_q;
    req_d      = req_q;
    imr_d      = imr_q;
    base_d     = base_q;
    aeoi_d     = aeoi_q;
    read_sel_d = read_sel_q;
    single_d   = single_q;
    icw4_d     = icw4_q;
    irq_sig_d  = irq_sig_q;
    irq_d      = irq_q;
    cur_d      = cur_q;
    dout_d     = dout_q;
    irr_clr    = 8'h00;
    isr_set    = 8'h00;
    isr_clr    = 8'h00;

    // Request handshake; the ack is judged against pre-write register values.
    case (req_q)
      REQ_IDLE: begin
        if (cand_vld && (init_q == INIT_READY)) begin
          req_d     = REQ_ACTIVE;
          irq_sig_d = 1'b1;
          irq_d     = base_q | {5'b00000, cand_idx};
          cur_d     = cand_idx;
        end
      end
      REQ_ACTIVE: begin
        if (irq_ack) begin
          // A line that was masked or cleared meanwhile makes the ack spurious.
          if (irr_q[cur_q] && !imr_q[cur_q]) begin
            irr_clr[cur_q] = 1'b1;
            if (!aeoi_q) isr_set[cur_q] = 1'b1;
          end
          req_d     = REQ_IDLE;
          irq_sig_d = 1'b0;
        end
      end
      default: req_d = REQ_IDLE;
    endcase

    if (wr && !icw1) begin
      case (init_q)
        INIT_READY: begin
          if (a0) begin
            imr_d = din;
          end else if (din[4:3] == 2'b00) begin
            if (din[7:5] == 3'b001)      isr_clr = isr_q & (~isr_q + 8'd1);
            else if (din[7:5] == 3'b011) isr_clr[din[2:0]] = 1'b1;
          end else if (din[1]) begin
            read_sel_d = din[0];
          end
        end
        INIT_ICW2: begin
          if (a0) begin
            base_d = din & 8'hF8;
            if (!single_q)   init_d = INIT_ICW3;
            else if (icw4_q) init_d = INIT_ICW4;
            else             init_d = INIT_READY;
          end
        end
        INIT_ICW3: begin
          if (a0) init_d = icw4_q ? INIT_ICW4 : INIT_READY;
        end
        INIT_ICW4: begin
          if (a0) begin
            aeoi_d = din[1];
            init_d = INIT_READY;
          end
        end
        default: init_d = INIT_READY;
      endcase
    end

    // A fresh edge beats a same-cycle ack clear on the same line.
    irr_d = (irr_q & ~irr_clr) | ir_edge;
    isr_d = (isr_q & ~isr_clr) | isr_set;

    // ICW1 restarts initialisation from any state and drops any live request.
    if (icw1) begin
      irr_d      = 8'h00;
      isr_d      = 8'h00;
      imr_d      = 8'h00;
      read_sel_d = 1'b0;
      aeoi_d     = 1'b0;
      single_d   = din[1];
      icw4_d     = din[0];
      req_d      = REQ_IDLE;
      irq_sig_d  = 1'b0;
      init_d     = INIT_ICW2;
    end

    if (rd) dout_d = a0 ? imr_q : (read_sel_q ? isr_q : irr_q);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_q     <= INIT_READY;
      req_q      <= REQ_IDLE;
      irr_q      <= 8'h00;
      isr_q      <= 8'h00;
      imr_q      <= 8'h00;
      base_q     <= VECTOR_RESET & 8'hF8;
      aeoi_q     <= AUTO_EOI_RESET;
      read_sel_q <= 1'b0;
      single_q   <= 1'b0;
      icw4_q     <= 1'b0;
      irq_sig_q  <= 1'b0;
      irq_q      <= 8'h00;
      cur_q      <= 3'd0;
      ir_prev_q  <= 8'h00;
      dout_q     <= 8'h00;
    end else begin
      init_q     <= init_d;
      req_q      <= req_d;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      imr_q      <= imr_d;
      base_q     <= base_d;
      aeoi_q     <= aeoi_d;
      read_sel_q <= read_sel_d;
      single_q   <= single_d;
      icw4_q     <= icw4_d;
      irq_sig_q  <= irq_sig_d;
      irq_q      <= irq_d;
      cur_q      <= cur_d;
      ir_prev_q  <= ir;
      dout_q     <= dout_d;
    end
  end

  assign dout       = dout_q;
  assign irq_signal = irq_sig_q;
  assign irq        = irq_q;

endmodule

// File: doc/pic_ctl.md
Name: pic_ctl

Overview:
- Single 8259-style programmable interrupt controller sequencing the CPU's irq_signal/irq interrupt interface.
- Latches eight edge-triggered request lines into IRR, applies IMR masking and fixed priority (IR0 highest) against the in-service register ISR, and presents one vector at a time to the CPU with an acknowledge handshake.
- Register access comes from the port controller (I/O 20h/21h decoded externally down to a0).

Parameters:
- VECTOR_RESET, 8'h08: vector base after reset; bits [2:0] ignored.
- AUTO_EOI_RESET, 0: auto-EOI mode after reset.

Ports:
- clock  in  1  system clock (CPU clock domain)
- reset_n  in  1  asynchronous active-low reset
- ir  in  8  interrupt request lines, already synchronous to clock, rising-edge sensitive
- a0  in  1  register select (0 = port 20h, 1 = port 21h)
- wr  in  1  one-cycle write strobe
- rd  in  1  one-cycle read strobe
- din  in  8  write data
- dout  out  8  read data, registered
- irq_signal  out  1  interrupt request to CPU, level
- irq  out  8  vector number, valid while irq_signal=1
- irq_ack  in  1  one-cycle CPU acknowledge

Behaviour:
- Reset (async): IRR=ISR=IMR=0, base=VECTOR_RESET&F8h, aeoi=AUTO_EOI_RESET, read_sel=IRR, init FSM=READY, req FSM=IDLE, ir_prev=0, dout=0, irq_signal=0, irq=0.
- Edge detect: edge = ir & ~ir_prev; ir_prev<=ir each cycle. IRR |= edge. An edge visible at posedge k sets IRR after k. irq_signal can rise at the earliest after k+1.
- Candidate: lowest index i with IRR[i] & ~IMR[i], valid only if i < lowest set ISR bit (or ISR=0).
- Req FSM IDLE: valid candidate and init FSM=READY -> REQ; irq<=base|i, irq_signal<=1.
- Req FSM REQ: irq and irq_signal are held stable until irq_ack.
  - On irq_ack, if IRR[i]&~IMR[i] still holds: clear IRR[i]; set ISR[i] unless aeoi.
  - Otherwise the ack is spurious: no register change (irq already showed base|7 is not required; vector stays as presented).
  - In both cases irq_signal<=0 -> IDLE, with at least 1 idle cycle before the next request.
  - irq_ack in IDLE is ignored.
- Same-cycle edge and ack on the same line: the clear loses and IRR[i] stays 1.
- Init FSM: wr, a0=0, din[4]=1 (ICW1) is accepted in any state.
  - Clears IMR, ISR and IRR; read_sel=IRR; aeoi=0.
  - Stores single=din[1] and icw4=din[0].
  - Forces req FSM to IDLE (irq_signal<=0).
  - Goes to ICW2.
- ICW2 (wr, a0=1): base<=din&F8h. Then -> ICW3 if !single, else ICW4 if icw4, else READY.
- ICW3 (wr, a0=1): data ignored. Then -> ICW4 if icw4, else READY.
- ICW4 (wr, a0=1): aeoi<=din[1]. Then -> READY.
- In ICW2/3/4, writes with a0=0 other than ICW1 are ignored.
- READY writes:
  - a0=1: IMR<=din (OCW1). Masking the pending line while in REQ makes the eventual ack spurious.
  - a0=0, din[4:3]=00 (OCW2):
    - din[7:5]=001: non-specific EOI, clears lowest-index set ISR bit.
    - din[7:5]=011: specific EOI, clears ISR[din[2:0]].
    - Other codes: ignored. EOI with ISR=0: no effect.
  - a0=0, din[4:3]=01 (OCW3): if din[1], read_sel<=din[0] (0=IRR, 1=ISR).
- Reads: on rd, dout<=(a0 ? IMR : read_sel ? ISR : IRR), valid the cycle after rd. dout holds otherwise. Reads have no side effects.
- Simultaneous wr and irq_ack in the same cycle: both take effect. The ack uses pre-write register values. EOI clear and ISR set on different bits both apply.
- Simultaneous wr and rd: the write takes effect; the read returns the pre-write value.

Test Plan:
- Reset, then ICW1=13h, ICW2=08h, ICW4=01h, OCW1=00h. Pulse ir[0] -> after 2 cycles irq_signal=1, irq=08h. After ack, irq_signal=0, ISR=01h, IRR=00h.
- Priority:
  - With ISR[0] set, pulse ir[3] and ir[1] together -> no request.
  - OCW2=20h -> irq=09h.
  - Ack, then OCW2=20h -> irq=0Bh.
- Masking:
  - IMR=04h, pulse ir[2] -> no request, IRR read (OCW3=0Ah) returns 04h.
  - IMR=00h -> irq=0Ah.
  - IMR=FFh while in REQ, then ack -> ISR unchanged, irq_signal drops.
- Auto-EOI: ICW1=13h, ICW2=70h, ICW4=03h. Pulse ir[7] -> irq=77h. After ack, ISR (OCW3=0Bh) reads 00h.
- ICW1 mid-request: while irq_signal=1, write ICW1 -> irq_signal=0 next cycle, IRR/ISR/IMR=00h, no request until ICW2/ICW4 done and a new edge.
- Async reset asserted during REQ -> all outputs 0 immediately, vector base 08h after release.
